mux_4_1_rr_arbiter: RTL and testbench

Round-robin arbiter and scheduler that shares one 4:1 datapath mux between four valid/ready requesters. It chooses the winning requester, drives the mux select and registers the selected beat into a single output stage. It sits upstream of any single-consumer datapath that is fed by four independent producers. Throughput is one beat per cycle with fair, starvation-free service.

---
 rtl/mux_arb_pkg.sv | 12 +
 rtl/mux_4_1_rr_arbiter_rr_pick_4.sv | 27 ++
 rtl/mux_4_1_rr_arbiter.sv | 75 +++++++
 tb/tb_mux_4_1_rr_arbiter.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/mux_arb_pkg.sv
// Shared types and helpers for the 4-requester round-robin arbiter.
package mux_arb_pkg;

    localparam int N_REQ = 4;

    typedef logic [1:0] req_idx_t;

    function automatic req_idx_t rr_next(input req_idx_t idx);
        return idx + 2'd1;
    endfunction

endpackage

// File: rtl/mux_4_1_rr_arbiter_rr_pick_4.sv
// Combinational round-robin pick: first valid index at or after ptr, mod 4.
module rr_pick_4
    import mux_arb_pkg::*;
(
    input  logic [N_REQ-1:0] in_valid,
    input  req_idx_t         ptr,
    output logic             grant_vld,
    output req_idx_t         grant_idx
);

    req_idx_t cand;

    // Scan from the farthest offset down so the nearest valid index wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = ptr;
        cand      = ptr;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = ptr + 2'(k);
            if (in_valid[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

endmodule

// File: rtl/mux_4_1_rr_arbiter.sv
// Round-robin arbiter driving a shared 4:1 mux into one registered output stage.
module mux_4_1_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] in_valid,
    output logic [N_REQ-1:0] in_ready,
    input  logic [WIDTH-1:0] in_data0,
    input  logic [WIDTH-1:0] in_data1,
    input  logic [WIDTH-1:0] in_data2,
    input  logic [WIDTH-1:0] in_data3,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       out_src
);

    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] FULL  = 1'b1;

    req_idx_t         ptr;
    logic             grant_vld;
    req_idx_t         grant_idx;
    logic             load;
    logic [WIDTH-1:0] sel_data;

    rr_pick_4 u_pick (
        .in_valid  (in_valid),
        .ptr       (ptr),
        .grant_vld (grant_vld),
        .grant_idx (grant_idx)
    );

    assign load = !((out_valid == FULL) && !out_ready);

    always_comb begin
        in_ready = '0;
        if (!rst && load && grant_vld) begin
            in_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        sel_data = in_data0;
        unique case (grant_idx)
            2'd0: sel_data = in_data0;
            2'd1: sel_data = in_data1;
            2'd2: sel_data = in_data2;
            2'd3: sel_data = in_data3;
        endcase
    end

    // A new beat may overwrite the old one in the same edge it drains.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= EMPTY;
            out_data  <= '0;
            out_src   <= '0;
            ptr       <= '0;
        end else if (load) begin
            if (grant_vld) begin
                out_valid <= FULL;
                out_data  <= sel_data;
                out_src   <= grant_idx;
                ptr       <= rr_next(grant_idx);
            end else begin
                out_valid <= EMPTY;
            end
        end
    end

endmodule

// File: tb/tb_mux_4_1_rr_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic vs a queue-free model.
module tb_mux_4_1_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] in_valid;
    logic [3:0] in_ready;
    logic [3:0] d [4];
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_data;
    logic [1:0] out_src;

    int checks = 0;
    int errors = 0;

    // Reference state, kept as plain integers
    int m_valid;
    int m_data;
    int m_src;
    int m_ptr;

    always #5 clk = ~clk;

    mux_4_1_rr_arbiter #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data0  (d[0]),
        .in_data1  (d[1]),
        .in_data2  (d[2]),
        .in_data3  (d[3]),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_src   (out_src)
    );

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // One cycle: drive at negedge, check in_ready, advance model, check outputs.
    task automatic step(input logic r, input logic [3:0] v, input logic ordy);
        int winner;
        int exp_ready;
        bit can_load;
        @(negedge clk);
        rst       = r;
        in_valid  = v;
        out_ready = ordy;
        #1;
        can_load = (m_valid == 0) || ordy;
        winner = -1;
        for (int k = 0; k < 4; k++) begin
            if (winner < 0 && v[(m_ptr + k) % 4]) winner = (m_ptr + k) % 4;
        end
        exp_ready = (!r && can_load && winner >= 0) ? (1 << winner) : 0;
        chk("in_ready", int'(in_ready), exp_ready);
        if (r) begin
            m_valid = 0; m_data = 0; m_src = 0; m_ptr = 0;
        end else if (can_load) begin
            if (winner >= 0) begin
                m_valid = 1;
                m_data  = int'(d[winner]);
                m_src   = winner;
                m_ptr   = (winner + 1) % 4;
            end else begin
                m_valid = 0;
            end
        end
        @(posedge clk);
        #1;
        chk("out_valid", int'(out_valid), m_valid);
        chk("out_data", int'(out_data), m_data);
        chk("out_src", int'(out_src), m_src);
    endtask

    initial begin
        int src_seq [5];
        rst = 1'b1;
        in_valid = '0;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) d[i] = '0;
        m_valid = 0; m_data = 0; m_src = 0; m_ptr = 0;

        // Reset held two cycles with everyone requesting
        step(1'b1, 4'b1111, 1'b1);
        step(1'b1, 4'b1111, 1'b1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), 0);
        step(1'b0, 4'b1111, 1'b1);

        // Single requester 2
        step(1'b1, 4'b0000, 1'b1);
        d[2] = 4'hA;
        step(1'b0, 4'b0100, 1'b1);
        chk("single_data", int'(out_data), 10);
        chk("single_src", int'(out_src), 2);

        // Four continuous requesters from ptr 0
        step(1'b1, 4'b0000, 1'b1);
        d[0] = 4'h1; d[1] = 4'h2; d[2] = 4'h3; d[3] = 4'h4;
        src_seq = '{0, 1, 2, 3, 0};
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 4'b1111, 1'b1);
            chk("rr_src", int'(out_src), src_seq[i]);
            chk("rr_data", int'(out_data), src_seq[i] + 1);
            chk("rr_nobubble", int'(out_valid), 1);
        end

        // Stall with everyone requesting; in_valid wiggles are ignored
        for (int i = 0; i < 3; i++) begin
            step(1'b0, (i == 1) ? 4'b0110 : 4'b1111, 1'b0);
            chk("stall_hold", int'(out_data), 1);
        end
        step(1'b0, 4'b1111, 1'b1);

        // Wrap and skip patterns
        step(1'b0, 4'b0010, 1'b1);
        step(1'b0, 4'b1001, 1'b1);
        chk("skip_src", int'(out_src), 3);
        step(1'b0, 4'b1001, 1'b1);
        chk("wrap_src", int'(out_src), 0);
        step(1'b0, 4'b0000, 1'b1);
        chk("idle_empty", int'(out_valid), 0);

        // Reset while FULL and stalled
        step(1'b0, 4'b1000, 1'b1);
        step(1'b1, 4'b1111, 1'b0);
        chk("midrst_valid", int'(out_valid), 0);
        step(1'b0, 4'b1111, 1'b1);
        chk("midrst_src", int'(out_src), 0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            for (int j = 0; j < 4; j++) d[j] = 4'($urandom);
            step(($urandom_range(0, 59) == 0), 4'($urandom),
                 ($urandom_range(0, 3) != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
